// File: rtl/cdb_arbiter.sv
// Completion-side CDB arbiter: per-FU completion FIFOs, round-robin grant of one result per cycle onto a registered CDB.
// Optional define CDB_MISPRED_FIRST_EN lets mispredicting heads pre-empt round-robin (lowest index first).
module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*XLEN-1:0]   fu_data,
    input  logic [NUM_FU*XLEN-1:0]   fu_target_pc,
    input  logic [NUM_FU-1:0]        fu_mispredict,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [XLEN-1:0]          cdb_data,
    output logic [XLEN-1:0]          cdb_target_pc,
    output logic                     cdb_mispredict
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned RR_W  = $clog2(NUM_FU);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic [XLEN-1:0]  target_pc;
        logic             mispredict;
    } entry_t;

    entry_t           mem_q   [NUM_FU][QDEPTH];
    entry_t           mem_d   [NUM_FU][QDEPTH];
    logic [PTR_W-1:0] head_q  [NUM_FU];
    logic [PTR_W-1:0] head_d  [NUM_FU];
    logic [PTR_W-1:0] tail_q  [NUM_FU];
    logic [PTR_W-1:0] tail_d  [NUM_FU];
    logic [CNT_W-1:0] count_q [NUM_FU];
    logic [CNT_W-1:0] count_d [NUM_FU];
    logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
    entry_t           cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;

    logic             grant_vld;
    logic [RR_W-1:0]  grant_idx;
    logic             mp_grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready depends only on registered occupancy, never on this cycle's grant.
    always_comb begin
        fu_ready = '0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            fu_ready[i] = (count_q[i] != CNT_W'(QDEPTH));
        end
    end

    // Scan from farthest to nearest so the first non-empty queue after rr_ptr is the last one written.
    always_comb begin
        int tmp;
        logic [RR_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        mp_grant  = 1'b0;
        tmp       = 0;
        cand      = '0;
        for (int k = int'(NUM_FU) - 1; k >= 0; k--) begin
            tmp = int'(rr_ptr_q) + k;
            if (tmp >= int'(NUM_FU)) tmp = tmp - int'(NUM_FU);
            cand = RR_W'(tmp);
            if (count_q[cand] != '0) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
`ifdef CDB_MISPRED_FIRST_EN
        for (int i = int'(NUM_FU) - 1; i >= 0; i--) begin
            if (count_q[i] != '0 && mem_q[i][head_q[i]].mispredict) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(i);
                mp_grant  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        logic push;
        logic pop;
        mem_d       = mem_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_d       = '0;
        push        = 1'b0;
        pop         = 1'b0;

        if (grant_vld) begin
            cdb_valid_d = 1'b1;
            cdb_d       = mem_q[grant_idx][head_q[grant_idx]];
            if (!mp_grant) begin
                rr_ptr_d = (grant_idx == RR_W'(NUM_FU - 1)) ? '0 : grant_idx + RR_W'(1);
            end
        end

        for (int i = 0; i < int'(NUM_FU); i++) begin
            push = fu_valid[i] && fu_ready[i];
            pop  = grant_vld && (grant_idx == RR_W'(i));
            if (push) begin
                mem_d[i][tail_q[i]] = '{tag:        fu_tag[i*TAG_W +: TAG_W],
                                        data:       fu_data[i*XLEN +: XLEN],
                                        target_pc:  fu_target_pc[i*XLEN +: XLEN],
                                        mispredict: fu_mispredict[i]};
                tail_d[i] = ptr_inc(tail_q[i]);
            end
            if (pop) head_d[i] = ptr_inc(head_q[i]);
            if (push && !pop) count_d[i] = count_q[i] + CNT_W'(1);
            else if (!push && pop) count_d[i] = count_q[i] - CNT_W'(1);
        end

        // Flush discards everything in flight, including this cycle's pushes and grant.
        if (flush) begin
            head_d      = '{default: '0};
            tail_d      = '{default: '0};
            count_d     = '{default: '0};
            rr_ptr_d    = '0;
            cdb_valid_d = 1'b0;
            cdb_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '{default: '0};
            tail_q      <= '{default: '0};
            count_q     <= '{default: '0};
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_q       <= cdb_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign cdb_valid      = cdb_valid_q;
    assign cdb_tag        = cdb_q.tag;
    assign cdb_data       = cdb_q.data;
    assign cdb_target_pc  = cdb_q.target_pc;
    assign cdb_mispredict = cdb_q.mispredict;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts queued at stimulus time, popped by a CDB monitor.
module tb_cdb_arbiter;

    localparam int unsigned NUM_FU = 4;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned TAG_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    flush;
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU-1:0]       fu_ready;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]  fu_data;
    logic [NUM_FU*XLEN-1:0]  fu_target_pc;
    logic [NUM_FU-1:0]       fu_mispredict;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_data;
    logic [XLEN-1:0]         cdb_target_pc;
    logic                    cdb_mispredict;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic [XLEN-1:0]  pc;
        logic             mp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    cdb_arbiter #(.NUM_FU(4), .QDEPTH(2), .XLEN(32), .TAG_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .fu_valid       (fu_valid),
        .fu_ready       (fu_ready),
        .fu_tag         (fu_tag),
        .fu_data        (fu_data),
        .fu_target_pc   (fu_target_pc),
        .fu_mispredict  (fu_mispredict),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_target_pc  (cdb_target_pc),
        .cdb_mispredict (cdb_mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    function automatic logic [31:0] mk_data(input int fu, input logic [3:0] tag);
        return 32'hC0DE_0000 | (32'(fu) << 8) | 32'(tag);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int fu, input logic [3:0] tag, input logic [31:0] data,
                       input logic mp, input logic [31:0] pc);
        fu_valid[fu]                = 1'b1;
        fu_tag[fu*TAG_W +: TAG_W]   = tag;
        fu_data[fu*XLEN +: XLEN]    = data;
        fu_target_pc[fu*XLEN +: XLEN] = pc;
        fu_mispredict[fu]           = mp;
    endtask

    task automatic expect_res(input logic [3:0] tag, input logic [31:0] data,
                              input logic mp, input logic [31:0] pc);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.pc   = pc;
        e.mp   = mp;
        exp_q.push_back(e);
    endtask

    // Drive and expect a plain (non-branch) result from one FU.
    task automatic go(input int fu, input logic [3:0] tag);
        drv(fu, tag, mk_data(fu, tag), 1'b0, 32'h0);
    endtask

    task automatic exp_go(input int fu, input logic [3:0] tag);
        expect_res(tag, mk_data(fu, tag), 1'b0, 32'h0);
    endtask

    task automatic idle_fu();
        fu_valid      = '0;
        fu_tag        = '0;
        fu_data       = '0;
        fu_target_pc  = '0;
        fu_mispredict = '0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
        tick();
        tick();
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Every broadcast must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && cdb_valid === 1'b1) begin
            chk("cdb_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("cdb_tag",  32'(cdb_tag), 32'(mon_e.tag));
                chk("cdb_data", cdb_data, mon_e.data);
                chk("cdb_pc",   cdb_target_pc, mon_e.pc);
                chk("cdb_mp",   32'(cdb_mispredict), 32'(mon_e.mp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle_fu();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_ready", 32'(fu_ready), 32'hF);
        chk("rst_tag",   32'(cdb_tag), 32'd0);
        chk("rst_data",  cdb_data, 32'd0);

        // Single result with two-cycle latency, rr_ptr -> 2
        drv(1, 4'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        expect_res(4'd5, 32'hDEAD_BEEF, 1'b0, 32'h0);
        tick();
        idle_fu();
        chk("single_nobypass", 32'(cdb_valid), 32'd0);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_tag",   32'(cdb_tag), 32'd5);
        tick();
        chk("single_drop", 32'(cdb_valid), 32'd0);
        chk("single_idle_data", cdb_data, 32'd0);
        wait_drain("single_drain");

        // Flush returns rr_ptr to 0
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush0_valid", 32'(cdb_valid), 32'd0);

        // Fairness from rr_ptr=0: 1,2,3,4 back-to-back
        for (int i = 0; i < 4; i++) begin
            go(i, 4'(i + 1));
            exp_go(i, 4'(i + 1));
        end
        tick();
        idle_fu();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_b2b_valid", 32'(cdb_valid), 32'd1);
        end
        tick();
        chk("rr_b2b_end", 32'(cdb_valid), 32'd0);
        wait_drain("rr0_drain");

        // Move rr_ptr to 2, then 3,4,1,2
        go(1, 4'd10);
        exp_go(1, 4'd10);
        tick();
        idle_fu();
        wait_drain("rr_move_drain");
        for (int i = 0; i < 4; i++) go(i, 4'(i + 1));
        exp_go(2, 4'd3);
        exp_go(3, 4'd4);
        exp_go(0, 4'd1);
        exp_go(1, 4'd2);
        tick();
        idle_fu();
        wait_drain("rr2_drain");

        // Backpressure on FU0 starting from rr_ptr=2
        exp_go(2, 4'd11); exp_go(3, 4'd12); exp_go(0, 4'd7);  exp_go(1, 4'd10);
        exp_go(2, 4'd14); exp_go(3, 4'd15); exp_go(0, 4'd8);  exp_go(1, 4'd13);
        exp_go(0, 4'd9);
        go(0, 4'd7); go(1, 4'd10); go(2, 4'd11); go(3, 4'd12);
        tick();
        go(0, 4'd8); go(1, 4'd13); go(2, 4'd14); go(3, 4'd15);
        tick();
        chk("bp_ready_full", 32'(fu_ready), 32'b0100);
        idle_fu();
        go(0, 4'd9);
        tick();
        chk("bp_ready_held", 32'(fu_ready), 32'b1100);
        tick();
        chk("bp_ready_rise", 32'(fu_ready), 32'b1101);
        tick();
        chk("bp_ready_after", 32'(fu_ready), 32'b1110);
        idle_fu();
        wait_drain("bp_drain");

        // Flush with five entries in flight (rr_ptr=1)
        for (int i = 0; i < 4; i++) go(i, 4'(i + 1));
        tick();
        idle_fu();
        go(0, 4'd5);
        go(1, 4'd6);
        exp_go(1, 4'd2);
        tick();
        idle_fu();
        flush = 1'b1;
        go(2, 4'd9);
        tick();
        flush = 1'b0;
        idle_fu();
        chk("flush_valid", 32'(cdb_valid), 32'd0);
        chk("flush_ready", 32'(fu_ready), 32'hF);
        chk("flush_tag",   32'(cdb_tag), 32'd0);
        for (int k = 0; k < 6; k++) tick();
        wait_drain("flush_drain");

        // Branch path from FU3
        drv(3, 4'd6, mk_data(3, 4'd6), 1'b1, 32'h0000_1000);
        expect_res(4'd6, mk_data(3, 4'd6), 1'b1, 32'h0000_1000);
        tick();
        idle_fu();
        tick();
        chk("br_mp", 32'(cdb_mispredict), 32'd1);
        chk("br_pc", cdb_target_pc, 32'h0000_1000);
        wait_drain("br_drain");

        // Only FU2 head mispredicts, rr_ptr=0
        for (int i = 0; i < 4; i++) begin
            if (i == 2) drv(i, 4'(i + 1), mk_data(i, 4'(i + 1)), 1'b1, 32'h0000_2000);
            else        go(i, 4'(i + 1));
        end
`ifdef CDB_MISPRED_FIRST_EN
        expect_res(4'd3, mk_data(2, 4'd3), 1'b1, 32'h0000_2000);
        exp_go(0, 4'd1);
        exp_go(1, 4'd2);
        exp_go(3, 4'd4);
`else
        exp_go(0, 4'd1);
        exp_go(1, 4'd2);
        expect_res(4'd3, mk_data(2, 4'd3), 1'b1, 32'h0000_2000);
        exp_go(3, 4'd4);
`endif
        tick();
        idle_fu();
        wait_drain("mpf_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Completion-side stage that sits directly upstream of the reorder buffer.
- Collects results from NUM_FU functional units into per-unit completion queues.
- Round-robin arbitrates one result per cycle onto the single common data bus (CDB).
- The registered CDB drives the ROB writeback inputs (tag, data, target PC, mispredict). The ROB flush signal clears all in-flight results.

Parameters:
- NUM_FU, 4, number of functional-unit completion ports (>=2).
- QDEPTH, 2, entries per completion queue (power of two, >=1).
- XLEN, 32, data/PC width.
- TAG_W, 4, ROB tag width.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- flush  in  1  ROB mispredict flush; clears queues and CDB
- fu_valid  in  NUM_FU  FU i presents a result
- fu_ready  out  NUM_FU  queue i can accept a result this cycle
- fu_tag  in  NUM_FU*TAG_W  ROB tag, FU i in bits [i*TAG_W +: TAG_W]
- fu_data  in  NUM_FU*XLEN  result value, same packing
- fu_target_pc  in  NUM_FU*XLEN  resolved branch target, same packing
- fu_mispredict  in  NUM_FU  branch mispredicted
- cdb_valid  out  1  broadcast valid (registered)
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_data  out  XLEN  broadcast result
- cdb_target_pc  out  XLEN  broadcast target PC
- cdb_mispredict  out  1  broadcast mispredict flag

Behaviour:
- Reset and flush (synchronous, identical effect):
  - all queues emptied (head, tail, count = 0).
  - rr_ptr = 0.
  - cdb_valid and every cdb_* output = 0 in the following cycle.
  - Pushes presented in the same cycle are dropped.
- Queue i:
  - circular FIFO of {tag, data, target_pc, mispredict}.
  - head/tail wrap modulo QDEPTH.
  - count ranges 0..QDEPTH.
- Push handshake:
  - fu_ready[i] = (count_i != QDEPTH), derived from registered state only; it does not depend on same-cycle grant.
  - Push occurs when fu_valid[i] && fu_ready[i].
  - fu_valid while !fu_ready is ignored; the FU must hold its result.
- Arbitration (combinational, each cycle):
  - candidates are all non-empty queues.
  - search order is rr_ptr, rr_ptr+1, ... modulo NUM_FU; the first candidate wins.
  - winner's head entry is popped and registered onto cdb_* at the clock edge; cdb_valid = 1 next cycle.
  - rr_ptr <= (winner+1) mod NUM_FU.
  - No candidate: cdb_valid <= 0, cdb_* <= 0, rr_ptr unchanged.
- Latency:
  - result pushed at edge E appears on the CDB at the earliest in the cycle after edge E+1 (2 cycles).
  - no bypass from fu_* to cdb_*.
- Simultaneous push and pop on the same queue: allowed when not full; count unchanged, order preserved.
- Full queue: pop in that cycle does not raise that cycle's fu_ready; ready rises the next cycle.
- Throughput: exactly one broadcast per cycle while any queue is non-empty.
- Per-FU ordering is FIFO. No ordering is guaranteed across FUs.
- cdb_valid is asserted for exactly one cycle per entry; no duplicates, no drops except on flush/reset.

Optional Feature:
- Macro: CDB_MISPRED_FIRST_EN.
- Defined:
  - any non-empty queue whose head has mispredict = 1 wins over round-robin; lowest index among such queues.
  - rr_ptr is not updated on such a grant.
- Undefined: pure round-robin as above; head mispredict does not affect arbitration.

Test Plan:
- Single result: reset; FU1 pushes tag=5, data=0xDEAD_BEEF at edge E -> cdb_valid=1, cdb_tag=5, cdb_data=0xDEADBEEF in cycle after E+1; cdb_valid=0 one cycle later.
- Round-robin fairness: all 4 FUs push in the same cycle, tags 1,2,3,4, rr_ptr=0 -> CDB tags 1,2,3,4 on consecutive cycles. Repeat with rr_ptr=2 -> 3,4,1,2.
- Backpressure: FU0 pushes tags 7,8 while FU1..3 also keep queues busy -> fu_ready[0]=0 once count=2; third push held; all three tags eventually broadcast in order 7,8,9.
- Flush mid-operation: queues hold 5 entries; flush=1 with FU2 pushing -> next cycle cdb_valid=0, all fu_ready=1, no stale tag ever broadcast.
- Branch path: FU3 pushes mispredict=1, target_pc=0x0000_1000 -> cdb_mispredict=1, cdb_target_pc=0x1000.
- CDB_MISPRED_FIRST_EN: FU0..3 heads with only FU2 mispredicting, rr_ptr=0 -> FU2 first, then 0,1,3. Undefined macro -> order 0,1,2,3.
